// File: rtl/br_counter_decr.sv
// Decrementing counter holding a value in [0, MaxValue], with a variable per-cycle decrement,
// saturating or wrapping underflow, reinitialisation, and registered zero/underflow flags.
module br_counter_decr #(
  parameter int MaxValue            = 1,
  parameter int MaxDecrement        = 1,
  parameter int InitialValue        = MaxValue,
  parameter int EnableReinitAndDecr = 1,
  parameter int EnableSaturate      = 0,
  localparam int ValueWidth         = $clog2(MaxValue + 1),
  localparam int DecrementWidth     = $clog2(MaxDecrement + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      reinit,
  input  logic [ValueWidth-1:0]     initial_value,
  input  logic                      decr_valid,
  input  logic [DecrementWidth-1:0] decr,
  output logic [ValueWidth-1:0]     value,
  output logic [ValueWidth-1:0]     value_next,
  output logic                      is_zero,
  output logic                      underflow
);

  localparam logic [ValueWidth-1:0]     MaxVal   = ValueWidth'(MaxValue);
  localparam logic [DecrementWidth-1:0] MaxDecr  = DecrementWidth'(MaxDecrement);
  localparam logic [ValueWidth-1:0]     InitVal  = ValueWidth'(InitialValue);
  localparam logic [ValueWidth:0]       Modulus  = (ValueWidth + 1)'(MaxValue + 1);

  if (MaxValue < 1) begin : gen_chk_max_value
    $error("br_counter_decr: MaxValue must be >= 1");
  end
  if (MaxDecrement < 1 || MaxDecrement > MaxValue) begin : gen_chk_max_decrement
    $error("br_counter_decr: MaxDecrement must be in 1..MaxValue");
  end
  if (InitialValue < 0 || InitialValue > MaxValue) begin : gen_chk_initial_value
    $error("br_counter_decr: InitialValue must be in 0..MaxValue");
  end

  // Result of an update whose decrement exceeds the base: clamp or wrap modulo MaxValue+1.
  function automatic logic [ValueWidth:0] underflow_result(input logic [ValueWidth:0] base,
                                                           input logic [ValueWidth:0] amount);
    if (EnableSaturate != 0) return '0;
    return base + Modulus - amount;
  endfunction

  logic [ValueWidth:0] base_ext;
  logic [ValueWidth:0] d_applied;
  logic [ValueWidth:0] next_ext;
  logic                uf;

  always_comb begin
    base_ext  = reinit ? {1'b0, initial_value} : {1'b0, value};
    d_applied = decr_valid ? (ValueWidth + 1)'(decr) : '0;
    if (reinit && (EnableReinitAndDecr == 0)) d_applied = '0;
    uf        = d_applied > base_ext;
    next_ext  = uf ? underflow_result(base_ext, d_applied) : base_ext - d_applied;
    value_next = ValueWidth'(next_ext);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value     <= InitVal;
      is_zero   <= (InitialValue == 0);
      underflow <= 1'b0;
    end else begin
      value     <= value_next;
      is_zero   <= (value_next == '0);
      underflow <= uf;
    end
  end

  a_decr_legal : assert property (@(posedge clk) disable iff (!rst_n)
    decr_valid |-> (decr <= MaxDecr));
  a_initial_value_legal : assert property (@(posedge clk) disable iff (!rst_n)
    reinit |-> (initial_value <= MaxVal));
  a_value_in_range : assert property (@(posedge clk) disable iff (!rst_n)
    value <= MaxVal);

endmodule

// File: tb/tb_br_counter_decr.sv
// Bench for br_counter_decr: three configurations (wrap, saturate, reinit-alone-wins) share one
// stimulus table; expected results flow through a scoreboard queue and are checked after each edge.
module tb_br_counter_decr;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       reinit;
  logic [3:0] initial_value;
  logic       decr_valid;
  logic [1:0] decr;

  logic [3:0] w_value, w_next, s_value, s_next, n_value, n_next;
  logic       w_zero, w_uf, s_zero, s_uf, n_zero, n_uf;

  always #5 clk = ~clk;

  br_counter_decr #(.MaxValue(10), .MaxDecrement(3), .InitialValue(10),
                    .EnableReinitAndDecr(1), .EnableSaturate(0)) u_wrap (
    .clk(clk), .rst_n(rst_n), .reinit(reinit), .initial_value(initial_value),
    .decr_valid(decr_valid), .decr(decr), .value(w_value), .value_next(w_next),
    .is_zero(w_zero), .underflow(w_uf));

  br_counter_decr #(.MaxValue(10), .MaxDecrement(3), .InitialValue(10),
                    .EnableReinitAndDecr(1), .EnableSaturate(1)) u_sat (
    .clk(clk), .rst_n(rst_n), .reinit(reinit), .initial_value(initial_value),
    .decr_valid(decr_valid), .decr(decr), .value(s_value), .value_next(s_next),
    .is_zero(s_zero), .underflow(s_uf));

  br_counter_decr #(.MaxValue(10), .MaxDecrement(3), .InitialValue(10),
                    .EnableReinitAndDecr(0), .EnableSaturate(0)) u_noer (
    .clk(clk), .rst_n(rst_n), .reinit(reinit), .initial_value(initial_value),
    .decr_valid(decr_valid), .decr(decr), .value(n_value), .value_next(n_next),
    .is_zero(n_zero), .underflow(n_uf));

  typedef struct {
    bit r; int iv; bit dv; int d;
    int ev; bit ez; bit eu;
  } vec_t;

  typedef struct {
    int wv; bit wz; bit wu;
    int sv; bit sz; bit su;
    int nv; bit nz; bit nu;
  } exp_t;

  vec_t tbl[23];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   ms, mn;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Reference behaviour for MaxValue=10.
  function automatic int mnext(input int v, input bit r, input int iv, input bit dv, input int d,
                               input bit er, input bit sat, output bit uf);
    int base, amt;
    base = r ? iv : v;
    amt  = dv ? d : 0;
    if (r && !er) amt = 0;
    uf = amt > base;
    if (!uf) return base - amt;
    return sat ? 0 : base + 11 - amt;
  endfunction

  task automatic drive(input bit r, input int iv, input bit dv, input int d);
    reinit        = r;
    initial_value = 4'(iv);
    decr_valid    = dv;
    decr          = 2'(d);
  endtask

  task automatic compare_pop(input int row);
    exp_t e;
    if (sb.size() == 0) begin
      chk($sformatf("sb_empty_row%0d", row), 0, 1);
      return;
    end
    e = sb.pop_front();
    chk($sformatf("wrap_value_row%0d", row), w_value, e.wv);
    chk($sformatf("wrap_zero_row%0d", row), w_zero, e.wz);
    chk($sformatf("wrap_uf_row%0d", row), w_uf, e.wu);
    chk($sformatf("sat_value_row%0d", row), s_value, e.sv);
    chk($sformatf("sat_zero_row%0d", row), s_zero, e.sz);
    chk($sformatf("sat_uf_row%0d", row), s_uf, e.su);
    chk($sformatf("noer_value_row%0d", row), n_value, e.nv);
    chk($sformatf("noer_zero_row%0d", row), n_zero, e.nz);
    chk($sformatf("noer_uf_row%0d", row), n_uf, e.nu);
  endtask

  initial begin
    exp_t e;
    bit   uf_s, uf_n;
    int   sn, nn;

    tbl[0]  = '{0, 0, 1, 3,  7, 0, 0};
    tbl[1]  = '{0, 0, 1, 3,  4, 0, 0};
    tbl[2]  = '{0, 0, 1, 3,  1, 0, 0};
    tbl[3]  = '{0, 0, 1, 3,  9, 0, 1};
    tbl[4]  = '{0, 0, 0, 0,  9, 0, 0};
    tbl[5]  = '{0, 0, 1, 3,  6, 0, 0};
    tbl[6]  = '{1, 5, 1, 2,  3, 0, 0};
    tbl[7]  = '{1, 1, 1, 3,  9, 0, 1};
    tbl[8]  = '{0, 0, 1, 3,  6, 0, 0};
    tbl[9]  = '{0, 0, 1, 2,  4, 0, 0};
    for (int i = 10; i < 15; i++) tbl[i] = '{0, 0, 0, 0, 4, 0, 0};
    tbl[15] = '{0, 0, 1, 0,  4, 0, 0};
    tbl[16] = '{0, 7, 0, 3,  4, 0, 0};
    tbl[17] = '{1, 1, 0, 0,  1, 0, 0};
    tbl[18] = '{0, 0, 1, 1,  0, 1, 0};
    tbl[19] = '{0, 0, 1, 1, 10, 0, 1};
    tbl[20] = '{0, 0, 1, 2,  8, 0, 0};
    tbl[21] = '{1, 0, 0, 0,  0, 1, 0};
    tbl[22] = '{0, 0, 1, 3,  8, 0, 1};

    rst_n = 1'b0;
    drive(0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_wrap_value", w_value, 10);
    chk("reset_wrap_zero", w_zero, 0);
    chk("reset_wrap_uf", w_uf, 0);
    chk("reset_sat_value", s_value, 10);
    chk("reset_noer_value", n_value, 10);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_release_value", w_value, 10);
    ms = 10;
    mn = 10;

    for (int i = 0; i < 23; i++) begin
      drive(tbl[i].r, tbl[i].iv, tbl[i].dv, tbl[i].d);
      sn = mnext(ms, tbl[i].r, tbl[i].iv, tbl[i].dv, tbl[i].d, 1'b1, 1'b1, uf_s);
      nn = mnext(mn, tbl[i].r, tbl[i].iv, tbl[i].dv, tbl[i].d, 1'b0, 1'b0, uf_n);
      e = '{tbl[i].ev, tbl[i].ez, tbl[i].eu, sn, (sn == 0), uf_s, nn, (nn == 0), uf_n};
      sb.push_back(e);
      #2;
      chk($sformatf("wrap_value_next_row%0d", i), w_next, tbl[i].ev);
      chk($sformatf("sat_value_next_row%0d", i), s_next, sn);
      chk($sformatf("noer_value_next_row%0d", i), n_next, nn);
      if (tbl[i].r == 0 && tbl[i].dv == 0)
        chk($sformatf("idle_hold_row%0d", i), w_next, w_value);
      ms = sn;
      mn = nn;
      @(posedge clk);
      #1;
      compare_pop(i);
    end
    chk("sb_drained", sb.size(), 0);

    // Underflow pending, then asynchronous reset asserted between edges.
    drive(1, 1, 0, 0);
    @(posedge clk);
    #1;
    drive(0, 0, 1, 3);
    @(posedge clk);
    #1;
    chk("pre_rst_wrap_value", w_value, 9);
    chk("pre_rst_wrap_uf", w_uf, 1);
    chk("pre_rst_sat_value", s_value, 0);
    chk("pre_rst_sat_zero", s_zero, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_wrap_value", w_value, 10);
    chk("async_rst_wrap_uf", w_uf, 0);
    chk("async_rst_wrap_zero", w_zero, 0);
    chk("async_rst_sat_value", s_value, 10);
    chk("async_rst_sat_zero", s_zero, 0);
    chk("async_rst_sat_uf", s_uf, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hold_wrap_value", w_value, 10);
    chk("rst_hold_wrap_uf", w_uf, 0);
    chk("rst_hold_noer_value", n_value, 10);
    drive(0, 0, 0, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("release_idle_value", w_value, 10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/br_counter_decr.md
Name: br_counter_decr

Overview:
Bedrock-RTL decrementing counter, the count-down companion to the incrementing counter. It subtracts a variable amount per cycle and holds a value in [0, MaxValue]. On underflow it either saturates at 0 or wraps to MaxValue. It supports reinitialisation and provides registered zero and underflow indications. Consumers are credit, timeout and drain logic that count down toward zero.

Parameters:
MaxValue, 1, maximum counter value, inclusive; must be >= 1.
MaxDecrement, 1, largest legal decrement, inclusive; must be 1..MaxValue.
InitialValue, MaxValue, constant loaded on asynchronous reset; must be <= MaxValue.
EnableReinitAndDecr, 1, 1: reinit and decr_valid in the same cycle apply the decrement to initial_value; 0: reinit alone wins.
EnableSaturate, 0, 1: underflow clamps to 0; 0: underflow wraps modulo MaxValue+1.
ValueWidth (localparam), $clog2(MaxValue+1), width of the value fields.
DecrementWidth (localparam), $clog2(MaxDecrement+1), width of decr.

Ports:
clk  input  1  clock; all state updates on its rising edge.
rst_n  input  1  asynchronous active-low reset.
reinit  input  1  load initial_value at the next edge.
initial_value  input  ValueWidth  reinit load value; must be <= MaxValue.
decr_valid  input  1  apply decr this cycle.
decr  input  DecrementWidth  decrement amount; must be <= MaxDecrement; ignored when decr_valid=0.
value  output  ValueWidth  registered counter value.
value_next  output  ValueWidth  combinational value that will be registered at the next edge.
is_zero  output  1  registered; 1 when value == 0.
underflow  output  1  registered one-cycle pulse; 1 when the previous update underflowed.

Behaviour:
- Reset: rst_n low forces value=InitialValue, is_zero=(InitialValue==0), underflow=0 immediately, without waiting for clk. Release is synchronised by the integrator.
- Effective decrement: d = decr_valid ? decr : 0.
- Base selection: base = reinit ? initial_value : value.
- Decrement applied: reinit=0 -> d; reinit=1 and EnableReinitAndDecr=1 -> d; reinit=1 and EnableReinitAndDecr=0 -> 0.
- Underflow test: uf = (d_applied > base), computed at ValueWidth+1 bits with no truncation.
- Result when uf=0: value_next = base - d_applied.
- Result when uf=1: EnableSaturate=1 -> 0; EnableSaturate=0 -> base + MaxValue + 1 - d_applied, computed at ValueWidth+1 bits. Wrap sequence is 1 -> 0 -> MaxValue.
- Registers at each edge: value<=value_next; is_zero<=(value_next==0); underflow<=uf.
- Zero-latency relation: value_next is combinational from the inputs. Update latency is 1 cycle.
- Idle: reinit=0 and decr_valid=0 -> value_next==value, underflow<=0.
- decr_valid=1 with decr=0: no change, no underflow.
- Range invariant: value <= MaxValue always, given legal inputs.
- Assertions, BR_ASSERT style, in RTL:
  - decr <= MaxDecrement when decr_valid=1.
  - initial_value <= MaxValue when reinit=1.
  - value <= MaxValue.
- Elaboration checks: MaxValue>=1; 1<=MaxDecrement<=MaxValue; InitialValue<=MaxValue.
- No internal state besides value, is_zero and underflow. No FSM beyond the counter register.

Test Plan:
1. MaxValue=10, MaxDecrement=3, InitialValue=10, wrap mode. Deassert rst_n, then apply decr=3 for three cycles -> value 10,7,4,1; is_zero=0; underflow=0 throughout.
2. Same setup at value=1, apply decr=3 -> value=9 next cycle, underflow=1 for exactly one cycle. With EnableSaturate=1 -> value=0, is_zero=1, underflow=1.
3. value=6, reinit=1, initial_value=5, decr_valid=1, decr=2:
   - EnableReinitAndDecr=1 -> value=3.
   - EnableReinitAndDecr=0 -> value=5.
   - In both cases underflow=0.
4. reinit=1, initial_value=1, decr=3, EnableReinitAndDecr=1, wrap mode -> value=9, underflow=1. Check value_next==9 combinationally in the same cycle.
5. value=4 and idle for 5 cycles -> value_next==value==4 every cycle. decr_valid=1 with decr=0 -> value stays 4, underflow=0.
6. value=2, underflow=1 pending. Pull rst_n low mid-cycle, between edges -> value=10, underflow=0, is_zero=0 before the next clk edge, and they hold while rst_n is low.
